pwm_frame_loader: RTL and testbench
===================================

# pwm_frame_loader

Upstream stage of the photonic-switch PWM generator. It produces the frame load strobe `clkZ`, the counter enable `en` and the double-buffered counter limits `A_val`/`B_val` consumed by the two down-counters of the PWM stage. New limits are accepted through a valid/ready write port into a shadow register. They are transferred to the outputs only at a frame boundary, so a frame never sees a half-updated A/B pair.

## Interface
- `W`, 7: width of `A_val`/`B_val` and of the write data
- `FRAME_W`, 8: width of `frame_len` and of the internal phase counter
- `clkCore`  in  1  single clock; every register updates on its rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  level, sampled each cycle; begin or resume frame generation
- `stop`  in  1  level, sampled each cycle; finish the current frame, then halt
- `frame_len`  in  FRAME_W  frame length in clkCore cycles; latched on the edge that sees `start` in IDLE; values 0 and 1 clamp to 2
- `wr_valid`  in  1  write request
- `wr_A`, `wr_B`  in  W  new limits
- `wr_ready`  out  1  `!pending`; a transfer completes on an edge where `wr_valid && wr_ready`
- `A_val`, `B_val`  out  W  active limits, registered
- `clkZ`  out  1  registered one-cycle frame load pulse
- `en`  out  1  registered; high in RUN and DRAIN
- `err`  out  1  registered one-cycle pulse; see Configuration

## Operation
- State IDLE:
  - `en` = 0, `clkZ` = 0.
  - `start` → RUN.
  - `stop` is ignored. `start` and `stop` both high → RUN.
- State RUN:
  - `en` = 1.
  - Phase counter `p` cycles 1 → 0 → len-1 → … → 1.
  - `stop` → DRAIN. `stop` and `start` both high → `start` wins and the state stays RUN.
- State DRAIN:
  - `en` = 1.
  - `start` → RUN (the stop is cancelled).
  - On the edge where `p` would become 1 → IDLE. That edge performs no shadow transfer, and no further `clkZ` is issued.
- Shadow register:
  - An accepted write loads the shadow and sets `pending`.
  - On every edge where `p` becomes 1, including the start edge: if `pending`, copy the shadow to `A_val`/`B_val` and clear `pending`.
- Write on a transfer edge:
  - A write can be accepted on a transfer edge only if `pending` was 0 before that edge.
  - The accepted data goes to the shadow and waits for the next frame.
  - The copy uses only shadow contents that existed before that edge.
- Writes are accepted in every state. In IDLE, data stays pending until the next start.
- `frame_len` changes are ignored outside the IDLE → RUN edge.
- Reset:
  - Forces IDLE, `p`=0, `pending`=0, and `A_val`=`B_val`=0.
  - Forces `clkZ`=`en`=`err`=0 and `wr_ready`=0.
  - Takes effect from any state, including mid-frame; an in-flight `clkZ` is cut.
  - `wr_ready` returns to 1 on the first cycle after reset deasserts.

## Timing
- `start` is sampled at edge E0: state=RUN, `en`=1, `p`=1, shadow transfer.
- E1: `clkZ`=1, `p`=0.
- E2: `clkZ`=0, `p`=len-1.
- Steady state: `clkZ` is high for exactly 1 cycle every len cycles.
- `A_val`/`B_val` change only at the edge exactly one cycle before `clkZ` rises, and stay stable for at least len-1 cycles afterwards. This gives setup margin for the PWM stage's `clkZ`-edge load.
- Write-to-output latency: at least 1 cycle, at most len cycles. The write reaches `A_val`/`B_val` at the next `p`→1 edge strictly after acceptance.
- Stop latency: the last `clkZ` is the one already scheduled in the current frame.
  - `en` falls on the edge where `p` would become 1.
  - `stop` asserted on the E0/E1 cycles of a frame still lets that frame's `clkZ` issue.

## Configuration
- Macro: `PWM_FRAME_LOADER_CHECK_EN`.
- Defined:
  - A handshaken write with `wr_A == 0` or `wr_B >= wr_A` completes normally but is discarded.
  - The shadow and `pending` are unchanged.
  - `err` pulses 1 cycle on the following cycle.
- Undefined: every write is stored and `err` is tied to 0.

## Test plan
- Reset, write A=40 B=10, then `start` with `frame_len`=100 → `A_val`=40/`B_val`=10 one cycle after start; `clkZ` at cycle 2, then every 100 cycles; `en`=1.
- While running, write A=60 B=20 at frame phase 50 → `wr_ready` low until the next `p`→1 edge; `A_val`/`B_val` change exactly 1 cycle before the next `clkZ`, not mid-frame.
- `frame_len`=0 and `frame_len`=1 → `clkZ` period is 2 cycles; `start`+`stop` together in IDLE → RUN.
- `stop` mid-frame → the pending `clkZ` of that frame issues, then `en`=0 and IDLE with no further `clkZ`; `start` during DRAIN → RUN continues without a gap.
- `reset` asserted mid-frame with a write pending → next cycle all outputs 0 and `pending` cleared; one cycle after deassert `wr_ready`=1.
- With `PWM_FRAME_LOADER_CHECK_EN`, write A=10 B=10 → `err` 1-cycle pulse and outputs unchanged; without the macro, the same write is applied and `err`=0.

Source files
------------

// File: rtl/pwm_frame_loader_if.sv
// pwm_frame_loader_if: valid/ready write port carrying new A/B counter limits
interface pwm_frame_loader_if #(parameter int W = 7);
  logic         wr_valid;
  logic         wr_ready;
  logic [W-1:0] wr_A;
  logic [W-1:0] wr_B;
  modport master (output wr_valid, wr_A, wr_B, input wr_ready);
  modport slave  (input wr_valid, wr_A, wr_B, output wr_ready);
endinterface

// File: rtl/pwm_frame_loader.sv
// pwm_frame_loader: frame strobe/enable generator with double-buffered A/B limits; optional write check via PWM_FRAME_LOADER_CHECK_EN
module pwm_frame_loader #(
  parameter int W       = 7,
  parameter int FRAME_W = 8
) (
  input  logic               clkCore,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [FRAME_W-1:0] frame_len,
  pwm_frame_loader_if.slave  wr,
  output logic [W-1:0]       A_val,
  output logic [W-1:0]       B_val,
  output logic               clkZ,
  output logic               en,
  output logic               err
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t             r_state, w_state_nx;
  logic [FRAME_W-1:0] r_p, r_len, w_p_nx, w_p_adv, w_len_nx;
  logic [W-1:0]       r_sh_a, r_sh_b, r_a, r_b;
  logic               r_pending, r_ready, r_clkz, r_en, r_err;
  logic               w_xfer, w_acc, w_bad, w_store, w_pend_nx;
  // Next state and phase: p counts down 1 -> 0 -> len-1 ... and a frame starts whenever p becomes 1
  always_comb begin
    w_p_adv    = (r_p == '0) ? r_len - FRAME_W'(1) : r_p - FRAME_W'(1);
    w_state_nx = r_state;
    w_p_nx     = w_p_adv;
    w_len_nx   = r_len;
    case (r_state)
      S_IDLE: begin
        w_p_nx = '0;
        if (start) begin
          w_state_nx = S_RUN;
          w_p_nx     = FRAME_W'(1);
          w_len_nx   = (frame_len < FRAME_W'(2)) ? FRAME_W'(2) : frame_len;
        end
      end
      S_RUN:   w_state_nx = (stop && !start) ? S_DRAIN : S_RUN;
      S_DRAIN: begin
        if (start) w_state_nx = S_RUN;
        else if (w_p_adv == FRAME_W'(1)) begin
          w_state_nx = S_IDLE;
          w_p_nx     = '0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_p_nx     = '0;
      end
    endcase
  end
  // Shadow control: the transfer uses pre-edge shadow contents, a same-edge write only refills the shadow
  always_comb begin
    w_xfer    = (w_state_nx != S_IDLE) && (w_p_nx == FRAME_W'(1));
    w_acc     = wr.wr_valid && r_ready;
`ifdef PWM_FRAME_LOADER_CHECK_EN
    w_bad     = w_acc && ((wr.wr_A == '0) || (wr.wr_B >= wr.wr_A));
`else
    w_bad     = 1'b0;
`endif
    w_store   = w_acc && !w_bad;
    w_pend_nx = w_store || (r_pending && !w_xfer);
  end
  // State register: FSM state, frame phase and the length latched at start
  always_ff @(posedge clkCore) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_len   <= FRAME_W'(2);
    end else begin
      r_state <= w_state_nx;
      r_p     <= w_p_nx;
      r_len   <= w_len_nx;
    end
  end
  // Datapath: registered strobes, shadow register and active limits
  always_ff @(posedge clkCore) begin
    if (reset) begin
      r_clkz    <= 1'b0;
      r_en      <= 1'b0;
      r_err     <= 1'b0;
      r_pending <= 1'b0;
      r_ready   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_sh_a    <= '0;
      r_sh_b    <= '0;
    end else begin
      r_clkz    <= (r_state != S_IDLE) && (r_p == FRAME_W'(1));
      r_en      <= w_state_nx != S_IDLE;
      r_err     <= w_bad;
      r_pending <= w_pend_nx;
      r_ready   <= !w_pend_nx;
      if (w_xfer && r_pending) begin
        r_a <= r_sh_a;
        r_b <= r_sh_b;
      end
      if (w_store) begin
        r_sh_a <= wr.wr_A;
        r_sh_b <= wr.wr_B;
      end
    end
  end
  assign wr.wr_ready = r_ready;
  assign A_val       = r_a;
  assign B_val       = r_b;
  assign clkZ        = r_clkz;
  assign en          = r_en;
  assign err         = r_err;
endmodule

// File: tb/tb_pwm_frame_loader.sv
// tb_pwm_frame_loader: directed and random stimulus checked against a frame-level reference model
module tb_pwm_frame_loader;
  localparam int W  = 7;
  localparam int FW = 8;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [FW-1:0] frame_len = '0;
  logic [W-1:0]  A_val, B_val;
  logic          clkZ, en, err;
  int            n_assert = 0;
  int            n_fail = 0;
  int            mode = 0;
  int            k = 0;
  int            len = 2;
  bit            m_pend = 0;
  logic [W-1:0]  sh_a = '0, sh_b = '0, e_a = '0, e_b = '0;
  bit            e_z = 0, e_en = 0, e_err = 0, e_rdy = 0;

  pwm_frame_loader_if #(.W(W)) wif();

  pwm_frame_loader #(.W(W), .FRAME_W(FW)) dut (
    .clkCore(clk), .reset(reset), .start(start), .stop(stop), .frame_len(frame_len),
    .wr(wif.slave), .A_val(A_val), .B_val(B_val), .clkZ(clkZ), .en(en), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: mode 0 idle, 1 run, 2 drain; k counts cycles since the current frame began
  task automatic model();
    bit acc, bad, sf;
    int kn;
    if (reset) begin
      mode = 0; k = 0; m_pend = 0; e_a = '0; e_b = '0;
      e_z = 0; e_en = 0; e_err = 0; e_rdy = 0;
      return;
    end
    acc = wif.wr_valid && e_rdy;
    e_z = (mode != 0) && (k == 0);
    sf  = 0;
    if (mode == 0) begin
      if (start) begin
        mode = 1; len = (frame_len < 2) ? 2 : int'(frame_len); k = 0; sf = 1;
      end
    end else begin
      kn = k + 1;
      if (mode == 2 && kn == len && !start) mode = 0;
      else begin
        if (kn == len) begin k = 0; sf = 1; end
        else k = kn;
        if (start) mode = 1;
        else if (stop && mode == 1) mode = 2;
      end
    end
    e_en = (mode != 0);
    if (sf && m_pend) begin e_a = sh_a; e_b = sh_b; m_pend = 0; end
    bad = 0;
`ifdef PWM_FRAME_LOADER_CHECK_EN
    bad = acc && (wif.wr_A == 0 || wif.wr_B >= wif.wr_A);
`endif
    e_err = bad;
    if (acc && !bad) begin sh_a = wif.wr_A; sh_b = wif.wr_B; m_pend = 1; end
    e_rdy = !m_pend;
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    chk("clkZ", clkZ, e_z);
    chk("en", en, e_en);
    chk("A_val", A_val, e_a);
    chk("B_val", B_val, e_b);
    chk("wr_ready", wif.wr_ready, e_rdy);
    chk("err", err, e_err);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [W-1:0] a, input logic [W-1:0] b);
    bit done;
    done = 0;
    wif.wr_valid = 1'b1; wif.wr_A = a; wif.wr_B = b;
    for (int i = 0; i < 300 && !done; i++) begin
      done = wif.wr_ready;
      tick();
    end
    wif.wr_valid = 1'b0;
    n_assert++;
    assert (done) else begin
      n_fail++;
      $error("FAIL write_timeout: accepted %0d required 1", done);
    end
  endtask

  task automatic rand_write();
    wif.wr_valid = ($urandom % 6 == 0);
    wif.wr_A = W'($urandom_range(1, 127));
    wif.wr_B = W'($urandom_range(0, int'(wif.wr_A)));
  endtask

  initial begin
    wif.wr_valid = 1'b0; wif.wr_A = '0; wif.wr_B = '0;
    run(2);
    chk("rst_clkZ", clkZ, 0);
    chk("rst_A", A_val, 0);
    chk("rst_rdy", wif.wr_ready, 0);
    reset = 1'b0;
    tick();
    chk("rdy_after_rst", wif.wr_ready, 1);
    wr(7'd40, 7'd10);
    frame_len = 8'd100; start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_A", A_val, 40);
    chk("first_B", B_val, 10);
    chk("first_en", en, 1);
    tick();
    chk("first_clkZ", clkZ, 1);
    for (int i = 0; i < 200 && k != 49; i++) tick();
    wr(7'd60, 7'd20);
    chk("mid_frame_A", A_val, 40);
    run(250);
    repeat (300) begin rand_write(); tick(); end
    wif.wr_valid = 1'b0;
    run(37);
    stop = 1'b1; tick(); stop = 1'b0;
    for (int i = 0; i < 300 && e_en; i++) tick();
    chk("stop_en", en, 0);
    run(5);
    frame_len = 8'd0; start = 1'b1; stop = 1'b1; tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_en", en, 1);
    run(8);
    stop = 1'b1; tick(); stop = 1'b0;
    for (int i = 0; i < 10 && e_en; i++) tick();
    frame_len = 8'd1; start = 1'b1; tick(); start = 1'b0;
    run(7);
    stop = 1'b1; tick(); stop = 1'b0;
    for (int i = 0; i < 10 && e_en; i++) tick();
    run(3);
    frame_len = 8'd10; start = 1'b1; tick(); start = 1'b0;
    run(12);
    stop = 1'b1; tick(); stop = 1'b0;
    run(3);
    start = 1'b1; tick(); start = 1'b0;
    run(25);
    chk("drain_resume_en", en, 1);
    wr(7'd5, 7'd2);
    run(2);
    reset = 1'b1; tick();
    chk("rst_mid_en", en, 0);
    chk("rst_mid_A", A_val, 0);
    reset = 1'b0; tick();
    chk("rst_mid_rdy", wif.wr_ready, 1);
    frame_len = 8'd20; start = 1'b1; tick(); start = 1'b0;
    run(5);
    wr(7'd10, 7'd10);
`ifdef PWM_FRAME_LOADER_CHECK_EN
    chk("bad_write_err", err, 1);
`else
    chk("bad_write_err", err, 0);
`endif
    run(40);
    repeat (800) begin
      start = ($urandom % 40 == 0);
      stop = ($urandom % 30 == 0);
      frame_len = FW'($urandom % 8);
      rand_write();
      tick();
    end
    start = 1'b0; stop = 1'b0; wif.wr_valid = 1'b0;
    run(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
